// File: rtl/regfile_pkg.sv
// Shared defaults, controller state encoding and zero word for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefNrd   = 2;

  typedef enum logic [0:0] {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [DefDataW-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Write ports, read ports and ready flag of the multi-port register file.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = regfile_pkg::DefDataW,
  parameter int unsigned ADDR_W = regfile_pkg::DefAddrW,
  parameter int unsigned NRD    = regfile_pkg::DefNrd
) ();

  logic                  we0;
  logic                  we1;
  logic [ADDR_W-1:0]     waddr0;
  logic [ADDR_W-1:0]     waddr1;
  logic [DATA_W-1:0]     wdata0;
  logic [DATA_W-1:0]     wdata1;
  logic [NRD-1:0]        re;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic                  ready;

  modport master (
    output we0, we1, waddr0, waddr1, wdata0, wdata1, re, raddr,
    input  rdata, ready
  );

  modport slave (
    input  we0, we1, waddr0, waddr1, wdata0, wdata1, re, raddr,
    output rdata, ready
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: gating, write-through bypass (port 1 over port 0), then storage.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              ready,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [DATA_W-1:0] Zero = DATA_W'(ZeroWord);

  always_comb begin
    rdata = Zero;
    if (!ready || (raddr == '0) || !re) begin
      rdata = Zero;
    end else if (we1 && (waddr1 == raddr)) begin
      rdata = wdata1;
    end else if (we0 && (waddr0 == raddr)) begin
      rdata = wdata0;
    end else begin
      rdata = stored;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NRD-read register file with a sequential clear controller; register 0 is hardwired zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NRD    = DefNrd
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int unsigned       Depth     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(Depth - 1);
  localparam logic [DATA_W-1:0] Zero      = DATA_W'(ZeroWord);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] mem [Depth];

  logic ready;
  logic clr_we;
  logic wr0_en;
  logic wr1_en;

  logic [DATA_W-1:0]     port_stored [NRD];
  logic [DATA_W-1:0]     port_rdata  [NRD];
  logic [NRD*DATA_W-1:0] rdata_packed;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StInit;
      clr_ptr_q <= FirstAddr;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // The pointer stops on the last address rather than wrapping back to 0.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      StInit: begin
        if (clr_ptr_q == LastAddr) begin
          state_d = StRun;
        end else begin
          clr_ptr_d = clr_ptr_q + FirstAddr;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_comb begin
    ready  = rst && (state_q == StRun);
    clr_we = rst && (state_q == StInit);
    wr1_en = ready && bus.we1 && (bus.waddr1 != '0);
    // Port 1 wins a same-address collision, so port 0 is suppressed outright.
    wr0_en = ready && bus.we0 && (bus.waddr0 != '0) &&
             !(wr1_en && (bus.waddr1 == bus.waddr0));
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr_q] <= Zero;
    end
    if (wr0_en) begin
      mem[bus.waddr0] <= bus.wdata0;
    end
    if (wr1_en) begin
      mem[bus.waddr1] <= bus.wdata1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign port_stored[i] = mem[bus.raddr[i*ADDR_W +: ADDR_W]];

    regfile_rd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_rd_port (
      .ready  (ready),
      .re     (bus.re[i]),
      .raddr  (bus.raddr[i*ADDR_W +: ADDR_W]),
      .we0    (bus.we0),
      .waddr0 (bus.waddr0),
      .wdata0 (bus.wdata0),
      .we1    (bus.we1),
      .waddr1 (bus.waddr1),
      .wdata1 (bus.wdata1),
      .stored (port_stored[i]),
      .rdata  (port_rdata[i])
    );
  end

  always_comb begin
    rdata_packed = '0;
    for (int i = 0; i < NRD; i++) begin
      rdata_packed[i*DATA_W +: DATA_W] = port_rdata[i];
    end
  end

  assign bus.rdata = rdata_packed;
  assign bus.ready = ready;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-006 we0, we1  input  1 each  write enables for write ports 0 and 1.
REQ-007 waddr0, waddr1  input  ADDR_W each  write addresses.
REQ-008 wdata0, wdata1  input  DATA_W each  write data.
REQ-009 re  input  NRD  per-read-port enable; bit i belongs to port i.
REQ-010 raddr  input  NRD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 rdata  output  NRD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W].
REQ-012 ready  output  1  high when the array is initialised and accepting writes.

Function
REQ-013 SHALL implement a two-state controller: INIT (sequential clear) and RUN.
REQ-014 In INIT, SHALL write zero to one register per cycle via a clear pointer (ADDR_W bits) starting at 1 and incrementing by 1.
REQ-015 On the edge that clears address DEPTH-1, SHALL move to RUN; the pointer SHALL NOT wrap.
REQ-016 ready SHALL be 0 in INIT and 1 in RUN; ready rises DEPTH-1 cycles after the first edge with rst=1.
REQ-017 While ready=0, SHALL ignore we0/we1 and drive all rdata ports to zero.
REQ-018 In RUN, each port SHALL write wdata to waddr on the rising edge when its we=1 and its waddr != 0.
REQ-019 Writes to address 0 SHALL be discarded; address 0 SHALL always read as zero.
REQ-020 If both ports write the same nonzero address in one cycle, port 1 SHALL win and port 0's data SHALL be discarded.
REQ-021 Reads SHALL be combinational (zero-cycle latency) with per-port priority: ready=0 -> 0; raddr=0 -> 0; re=0 -> 0; match waddr1 with we1=1 -> wdata1; match waddr0 with we0=1 -> wdata0; else stored value.
REQ-022 Bypass SHALL use only the enable and address of each port; no read port SHALL depend on another port's re.
REQ-023 All NRD read ports SHALL be independent and may read the same address in the same cycle.

Reset
REQ-024 With rst=0 at a rising edge: state <= INIT, clear pointer <= 1, and no array write occurs that cycle.
REQ-025 While rst=0, ready SHALL be 0 and every rdata port SHALL be 0.
REQ-026 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear sequence; earlier contents SHALL be unobservable afterwards.
REQ-027 The array SHALL have no direct reset; clearing SHALL occur only through the INIT sequence.

Structure
REQ-028 A shared package regfile_pkg SHALL hold the default DATA_W/ADDR_W/NRD values, the INIT/RUN state encoding, and the zero-word constant.
REQ-029 The per-port bypass/priority mux SHALL be a sub-module regfile_rd_port, instantiated NRD times via generate.
REQ-030 The storage array, write arbitration and clear controller SHALL live in regfile_mp.

Verification
REQ-031 Release reset, poll ready -> ready=0 for exactly 31 cycles (defaults), then 1; every register reads 0 afterwards.
REQ-032 In RUN, we0=1 waddr0=3 wdata0=0x1234_5678 with re[0]=1 raddr[0]=3 in the same cycle -> rdata port 0 = 0x1234_5678 that cycle and the next.
REQ-033 we0=1 and we1=1, both at address 7, wdata0=0xAAAA_AAAA, wdata1=0x5555_5555 -> same-cycle bypass and later read both return 0x5555_5555.
REQ-034 we1=1 waddr1=0 wdata1=0xFFFF_FFFF, read addr 0 on both ports with re=2'b11 -> both return 0 that cycle and after.
REQ-035 Write 0xDEAD_BEEF to reg 9, assert rst=0 for 1 cycle mid-RUN, release -> ready=0 for 31 cycles, a write to reg 9 during INIT is ignored, and reg 9 reads 0 after ready.
REQ-036 re=2'b01 with raddr port1=9 holding 0xDEAD_BEEF -> port 1 = 0 and port 0 unaffected.
